// File: rtl/clk_monitor_if.sv
// clk_monitor_if: control inputs and measurement results of the
// clock monitor, bundled between the stimulus side and the monitor.
interface clk_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             mon_clk;
  logic [CNT_W-1:0] exp_high;
  logic [CNT_W-1:0] exp_low;
  logic [3:0]       tol;
  logic [CNT_W-1:0] meas_high;
  logic [CNT_W-1:0] meas_low;
  logic [CNT_W:0]   period;
  logic             valid;
  logic             mismatch;
  logic             timeout;
  logic [15:0]      periods;

  modport master (
    output en, mon_clk, exp_high, exp_low, tol,
    input  meas_high, meas_low, period,
    input  valid, mismatch, timeout, periods
  );

  modport slave (
    input  en, mon_clk, exp_high, exp_low, tol,
    output meas_high, meas_low, period,
    output valid, mismatch, timeout, periods
  );
endinterface

// File: rtl/clk_monitor.sv
// clk_monitor: measures high/low phases of a divided clock against
// expected lengths; flags deviations and stalled phases.
module clk_monitor #(
  parameter int CNT_W = 8
) (
  input logic          clk_in,
  input logic          rst,
  clk_monitor_if.slave mon_if
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic             r_s1;
  logic             r_s2;
  logic             r_d;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_meas_high;
  logic [CNT_W-1:0] r_meas_low;
  logic [CNT_W:0]   r_period;
  logic             r_valid;
  logic             r_mismatch;
  logic             r_timeout;
  logic [15:0]      r_periods;
  logic             w_clr;
  logic             w_start;
  logic             w_inc;
  logic             w_sat;
  logic             w_done_hi;
  logic             w_done_lo;
  logic             w_bad_hi;
  logic             w_bad_lo;

  // Distance computed one bit wider so m - e never wraps.
  function automatic logic out_of_tol(
    input logic [CNT_W-1:0] m,
    input logic [CNT_W-1:0] e,
    input logic [3:0]       t
  );
    logic [CNT_W:0] a;
    logic [CNT_W:0] b;
    logic [CNT_W:0] d;
    a = {1'b0, m};
    b = {1'b0, e};
    d = (a >= b) ? (a - b) : (b - a);
    return d > (CNT_W+1)'(t);
  endfunction

  assign w_rise   = r_s2 & ~r_d;
  assign w_fall   = ~r_s2 & r_d;
  assign w_bad_hi = out_of_tol(r_cnt, mon_if.exp_high, mon_if.tol);
  assign w_bad_lo = out_of_tol(r_cnt, mon_if.exp_low, mon_if.tol);

  // Two-flop synchronizer plus delay flop for edge detection.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_d  <= 1'b0;
    end else begin
      r_s1 <= mon_if.mon_clk;
      r_s2 <= r_s1;
      r_d  <= r_s2;
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and datapath strobes; dropping en wins over everything.
  always_comb begin
    w_next    = r_state;
    w_clr     = 1'b0;
    w_start   = 1'b0;
    w_inc     = 1'b0;
    w_sat     = 1'b0;
    w_done_hi = 1'b0;
    w_done_lo = 1'b0;
    if (!mon_if.en) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_next = WAIT_RISE;
          w_clr  = 1'b1;
        end
        WAIT_RISE: begin
          if (w_rise) begin
            w_next  = MEAS_HIGH;
            w_start = 1'b1;
          end
        end
        MEAS_HIGH: begin
          if (w_fall) begin
            w_next    = MEAS_LOW;
            w_done_hi = 1'b1;
          end else if (r_cnt == CNT_MAX) begin
            w_next = WAIT_RISE;
            w_sat  = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (w_rise) begin
            w_next    = MEAS_HIGH;
            w_done_lo = 1'b1;
          end else if (r_cnt == CNT_MAX) begin
            w_next = WAIT_RISE;
            w_sat  = 1'b1;
          end else begin
            w_inc = 1'b1;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  // Phase counter, results, sticky flags and period count.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_meas_high <= '0;
      r_meas_low  <= '0;
      r_period    <= '0;
      r_valid     <= 1'b0;
      r_mismatch  <= 1'b0;
      r_timeout   <= 1'b0;
      r_periods   <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_clr) begin
        r_mismatch <= 1'b0;
        r_timeout  <= 1'b0;
        r_periods  <= '0;
      end
      if (w_start) r_cnt <= CNT_ONE;
      if (w_inc)   r_cnt <= r_cnt + CNT_ONE;
      if (w_sat)   r_timeout <= 1'b1;
      if (w_done_hi) begin
        r_meas_high <= r_cnt;
        r_cnt       <= CNT_ONE;
        if (w_bad_hi) r_mismatch <= 1'b1;
      end
      if (w_done_lo) begin
        r_meas_low <= r_cnt;
        r_period   <= {1'b0, r_meas_high} + {1'b0, r_cnt};
        r_valid    <= 1'b1;
        r_periods  <= r_periods + 16'd1;
        r_cnt      <= CNT_ONE;
        if (w_bad_lo) r_mismatch <= 1'b1;
      end
    end
  end

  assign mon_if.meas_high = r_meas_high;
  assign mon_if.meas_low  = r_meas_low;
  assign mon_if.period    = r_period;
  assign mon_if.valid     = r_valid;
  assign mon_if.mismatch  = r_mismatch;
  assign mon_if.timeout   = r_timeout;
  assign mon_if.periods   = r_periods;

endmodule

// File: tb/tb_clk_monitor.sv
// tb_clk_monitor: directed stimulus for clk_monitor with
// hand-derived expected values checked by immediate assertions.
module tb_clk_monitor;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;

  int checks    = 0;
  int errors    = 0;
  int cyc       = 0;
  int last_rise = -100;
  int vcount    = 0;
  int half      = 2;
  int pc        = 0;
  bit div_on    = 1'b0;

  clk_monitor_if #(.CNT_W(8)) mif ();

  clk_monitor #(.CNT_W(8)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .mon_if (mif)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clk_in cycle: sample at negedge, then drive mon_clk.
  task automatic step();
    @(negedge clk_in);
    cyc++;
    if (mif.valid === 1'b1) begin
      vcount++;
      chk("valid_latency", 32'(cyc - last_rise), 32'd3);
    end
    if (div_on) begin
      pc++;
      if (pc == half) begin
        mif.mon_clk = ~mif.mon_clk;
        pc = 0;
        if (mif.mon_clk) last_rise = cyc;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_div(input int h);
    step();
    half        = h;
    pc          = 0;
    div_on      = 1'b1;
    mif.mon_clk = 1'b1;
    last_rise   = cyc;
    vcount      = 0;
  endtask

  task automatic reenable(input int hi, input int lo, input int t);
    div_on      = 1'b0;
    mif.mon_clk = 1'b0;
    mif.en      = 1'b0;
    run(4);
    mif.exp_high = 8'(hi);
    mif.exp_low  = 8'(lo);
    mif.tol      = 4'(t);
    mif.en       = 1'b1;
    run(4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_meas_high"}, 32'(mif.meas_high), 32'd0);
    chk({tag, "_meas_low"},  32'(mif.meas_low),  32'd0);
    chk({tag, "_period"},    32'(mif.period),    32'd0);
    chk({tag, "_valid"},     32'(mif.valid),     32'd0);
    chk({tag, "_mismatch"},  32'(mif.mismatch),  32'd0);
    chk({tag, "_timeout"},   32'(mif.timeout),   32'd0);
    chk({tag, "_periods"},   32'(mif.periods),   32'd0);
  endtask

  initial begin
    mif.en       = 1'b0;
    mif.mon_clk  = 1'b0;
    mif.exp_high = 8'd2;
    mif.exp_low  = 8'd2;
    mif.tol      = 4'd0;

    run(3);
    chk_all_zero("reset");
    rst = 1'b0;
    run(2);
    mif.en = 1'b1;
    run(4);

    // clk_in/4: 2/2 phases, tolerance 0
    start_div(2);
    run(39);
    chk("div4_meas_high", 32'(mif.meas_high), 32'd2);
    chk("div4_meas_low",  32'(mif.meas_low),  32'd2);
    chk("div4_period",    32'(mif.period),    32'd4);
    chk("div4_periods",   32'(mif.periods),   32'd9);
    chk("div4_mismatch",  32'(mif.mismatch),  32'd0);
    chk("div4_timeout",   32'(mif.timeout),   32'd0);

    // clk_in/28: 14/14 phases
    reenable(14, 14, 0);
    chk("div28_clr_periods", 32'(mif.periods), 32'd0);
    start_div(14);
    run(31);
    chk("div28_periods1",   32'(mif.periods),   32'd1);
    chk("div28_period",     32'(mif.period),    32'd28);
    chk("div28_meas_high",  32'(mif.meas_high), 32'd14);
    chk("div28_meas_low",   32'(mif.meas_low),  32'd14);
    run(28);
    chk("div28_periods2",   32'(mif.periods),   32'd2);
    chk("div28_mismatch",   32'(mif.mismatch),  32'd0);
    chk("div28_timeout",    32'(mif.timeout),   32'd0);

    // clk_in/16 against expected high of 6, tolerance 1
    reenable(6, 8, 1);
    start_div(8);
    run(10);
    chk("div16_mm_before", 32'(mif.mismatch), 32'd0);
    run(1);
    chk("div16_mm_set",    32'(mif.mismatch), 32'd1);
    chk("div16_meas_high", 32'(mif.meas_high), 32'd8);
    run(40);
    chk("div16_mm_sticky", 32'(mif.mismatch), 32'd1);
    chk("div16_periods",   32'(mif.periods),  32'd3);
    chk("div16_meas_low",  32'(mif.meas_low), 32'd8);

    // mon_clk stuck high: saturate at 255
    reenable(8, 8, 0);
    chk("stuck_mm_clr", 32'(mif.mismatch), 32'd0);
    start_div(1000);
    run(257);
    chk("stuck_to_before", 32'(mif.timeout), 32'd0);
    run(1);
    chk("stuck_to_set",    32'(mif.timeout), 32'd1);
    run(42);
    chk("stuck_to_sticky", 32'(mif.timeout),   32'd1);
    chk("stuck_periods",   32'(mif.periods),   32'd0);
    chk("stuck_meas_high", 32'(mif.meas_high), 32'd8);
    chk("stuck_no_valid",  32'(vcount),        32'd0);

    // 255/255 phases end exactly on the saturating cycle
    reenable(255, 255, 0);
    chk("max_to_clr", 32'(mif.timeout), 32'd0);
    start_div(255);
    run(258);
    chk("max_hi_timeout", 32'(mif.timeout),   32'd0);
    chk("max_meas_high",  32'(mif.meas_high), 32'd255);
    chk("max_hi_mm",      32'(mif.mismatch),  32'd0);
    run(255);
    chk("max_valid",      32'(mif.valid),     32'd1);
    chk("max_period",     32'(mif.period),    32'd510);
    chk("max_meas_low",   32'(mif.meas_low),  32'd255);
    chk("max_periods",    32'(mif.periods),   32'd1);
    chk("max_lo_timeout", 32'(mif.timeout),   32'd0);

    // en dropped mid low phase, then raised again
    reenable(6, 8, 1);
    start_div(8);
    run(30);
    chk("endrop_periods_pre", 32'(mif.periods),  32'd1);
    chk("endrop_mm_pre",      32'(mif.mismatch), 32'd1);
    mif.en = 1'b0;
    vcount = 0;
    run(8);
    chk("endrop_no_valid",  32'(vcount),        32'd0);
    chk("endrop_hold_per",  32'(mif.periods),   32'd1);
    chk("endrop_hold_mm",   32'(mif.mismatch),  32'd1);
    chk("endrop_hold_high", 32'(mif.meas_high), 32'd8);
    mif.en = 1'b1;
    run(1);
    chk("reen_periods_clr", 32'(mif.periods),  32'd0);
    chk("reen_mm_clr",      32'(mif.mismatch), 32'd0);
    run(19);
    chk("reen_mm_partial",  32'(mif.mismatch), 32'd0);
    run(1);
    chk("reen_mm_first",    32'(mif.mismatch), 32'd1);
    run(7);
    chk("reen_periods0",    32'(mif.periods),  32'd0);
    run(1);
    chk("reen_periods1",    32'(mif.periods),  32'd1);
    chk("reen_valid",       32'(mif.valid),    32'd1);

    // async reset pulse between clock edges during a high phase
    run(2);
    #1 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    #1 rst = 1'b0;
    vcount = 0;
    run(8);
    chk("post_rst_no_valid", 32'(vcount),      32'd0);
    chk("post_rst_periods",  32'(mif.periods), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
